// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: holds all domain resets, then releases them in index order,
// waiting for each ack plus a programmable gap. Optional ack timeout via `SEQ_ACK_TIMEOUT_EN.
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned DLY_WIDTH   = 8,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [DLY_WIDTH-1:0]   DLY_GAP,
  input  logic [NUM_DOMAINS-1:0] DOM_ACK,
  output logic [NUM_DOMAINS-1:0] DOM_RST_N,
  output logic                   SEQ_BUSY,
  output logic                   SEQ_DONE,
  output logic                   TIMEOUT_ERR
);

  localparam int unsigned IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CNT_A  = (HOLD_W > DLY_WIDTH) ? HOLD_W : DLY_WIDTH;
  localparam int unsigned CNT_W  = (TMO_W > CNT_A) ? TMO_W : CNT_A;

  localparam logic [2:0] S_HOLD     = 3'd0;
  localparam logic [2:0] S_RELEASE  = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]             state, state_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_DOMAINS-1:0] rst_n_nxt;
  logic                   busy_nxt, done_nxt;
  logic                   adv;

`ifdef SEQ_ACK_TIMEOUT_EN
  logic terr_q, terr_nxt;
  assign TIMEOUT_ERR = terr_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

  // State and registered outputs; RST overrides everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_HOLD;
      idx       <= '0;
      cnt       <= '0;
      DOM_RST_N <= '0;
      SEQ_BUSY  <= 1'b1;
      SEQ_DONE  <= 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      terr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      DOM_RST_N <= rst_n_nxt;
      SEQ_BUSY  <= busy_nxt;
      SEQ_DONE  <= done_nxt;
`ifdef SEQ_ACK_TIMEOUT_EN
      terr_q    <= terr_nxt;
`endif
    end
  end

  // Next state, counters and output values
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    rst_n_nxt = DOM_RST_N;
    busy_nxt  = SEQ_BUSY;
    done_nxt  = SEQ_DONE;
    adv       = 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
    terr_nxt  = terr_q;
`endif

    if (SW_RST_REQ) begin
      state_nxt = S_HOLD;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      rst_n_nxt = '0;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
`ifdef SEQ_ACK_TIMEOUT_EN
      terr_nxt  = 1'b0;
`endif
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            state_nxt = S_RELEASE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          rst_n_nxt[idx] = 1'b1;
          state_nxt      = S_WAIT_ACK;
          cnt_nxt        = '0;
        end
        S_WAIT_ACK: begin
          adv = DOM_ACK[idx];
`ifdef SEQ_ACK_TIMEOUT_EN
          // An ack on the final timeout cycle wins and raises no error
          if (!DOM_ACK[idx]) begin
            if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
              adv      = 1'b1;
              terr_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
`endif
          if (adv) begin
            if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
              busy_nxt  = 1'b0;
            end else if (DLY_GAP == '0) begin
              state_nxt = S_RELEASE;
              idx_nxt   = idx + IDX_W'(1);
            end else begin
              state_nxt = S_GAP;
              cnt_nxt   = CNT_W'(DLY_GAP);
            end
          end
        end
        S_GAP: begin
          if (cnt <= CNT_W'(1)) begin
            state_nxt = S_RELEASE;
            idx_nxt   = idx + IDX_W'(1);
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_nxt = S_DONE;
        end
        default: begin
          state_nxt = S_HOLD;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus randomized ack/gap/restart runs checked
// against a release-schedule model computed from per-domain ack delays and gaps.
module tb_rst_seq_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned HC = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          SW_RST_REQ;
  logic [DW-1:0] DLY_GAP;
  logic [ND-1:0] DOM_ACK;
  logic [ND-1:0] DOM_RST_N;
  logic          SEQ_BUSY;
  logic          SEQ_DONE;
  logic          TIMEOUT_ERR;

  int checks = 0;
  int errors = 0;

  // Schedule model, edges counted from the restart edge (edge 0)
  int d_ack[ND];
  int g_gap[ND];
  int t_rel[ND];
  int a_acc[ND];
  int rise[ND];
  int done_at;

  always #5 CLK = ~CLK;

  rst_seq_ctrl #(
    .NUM_DOMAINS(ND),
    .DLY_WIDTH  (DW),
    .HOLD_CYCLES(HC),
    .ACK_TIMEOUT(16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .DLY_GAP    (DLY_GAP),
    .DOM_ACK    (DOM_ACK),
    .DOM_RST_N  (DOM_RST_N),
    .SEQ_BUSY   (SEQ_BUSY),
    .SEQ_DONE   (SEQ_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Release k at t_rel, ack seen d_ack+1 edges later, then gap+1 edges to the next release
  task automatic sched();
    int t;
    t = HC + 1;
    for (int k = 0; k < ND; k++) begin
      t_rel[k] = t;
      a_acc[k] = t + d_ack[k] + 1;
      t = a_acc[k] + g_gap[k] + 1;
    end
  endtask

  task automatic plan(input bit rnd, input int gfix);
    for (int k = 0; k < ND; k++) begin
      d_ack[k] = rnd ? int'($urandom_range(0, 6)) : 0;
      g_gap[k] = rnd ? int'($urandom_range(0, 5)) : gfix;
    end
    sched();
  endtask

  // Restart edge(s): RST held m edges (kind 0), SW pulse (1), SW with RST (2)
  task automatic restart(input int kind, input int m);
    int edges;
    edges = (kind == 0) ? m : 1;
    for (int e = 0; e < edges; e++) begin
      RST        = (kind != 1);
      SW_RST_REQ = (kind != 0);
      DOM_ACK    = ND'($urandom);
      DLY_GAP    = DW'($urandom);
      @(posedge CLK);
      #1;
      chk("rst_dom_rst_n", 32'(DOM_RST_N), 32'(0));
      chk("rst_busy", 32'(SEQ_BUSY), 32'(1));
      chk("rst_done", 32'(SEQ_DONE), 32'(0));
      chk("rst_timeout_err", 32'(TIMEOUT_ERR), 32'(0));
    end
    RST        = 1'b0;
    SW_RST_REQ = 1'b0;
  endtask

  // Inputs for edge n: the current domain's ack is low until its acceptance edge, everything
  // else (other ack bits, DLY_GAP away from acceptance) is noise
  task automatic drive_for(input int n);
    logic [ND-1:0] ack;
    logic [DW-1:0] gap;
    gap = DW'($urandom);
    for (int k = 0; k < ND; k++) begin
      if (n > t_rel[k] && n < a_acc[k]) ack[k] = 1'b0;
      else if (n == a_acc[k]) ack[k] = 1'b1;
      else ack[k] = 1'($urandom);
      if (n == a_acc[k]) gap = DW'(g_gap[k]);
    end
    DOM_ACK = ack;
    DLY_GAP = gap;
  endtask

  task automatic run(input int len);
    logic [ND-1:0] exp_rst_n;
    bit            exp_done;
    for (int k = 0; k < ND; k++) rise[k] = -1;
    done_at = -1;
    for (int n = 1; n <= len; n++) begin
      drive_for(n);
      @(posedge CLK);
      #1;
      for (int k = 0; k < ND; k++) begin
        exp_rst_n[k] = (n >= t_rel[k]);
        if (rise[k] < 0 && DOM_RST_N[k] === 1'b1) rise[k] = n;
      end
      if (done_at < 0 && SEQ_DONE === 1'b1) done_at = n;
      exp_done = (n >= a_acc[ND-1]);
      chk("dom_rst_n", 32'(DOM_RST_N), 32'(exp_rst_n));
      chk("seq_done", 32'(SEQ_DONE), 32'(exp_done));
      chk("seq_busy", 32'(SEQ_BUSY), 32'(!exp_done));
      chk("timeout_err", 32'(TIMEOUT_ERR), 32'(0));
    end
  endtask

  initial begin
    int full;
    int kind;
    RST        = 1'b1;
    SW_RST_REQ = 1'b0;
    DLY_GAP    = '0;
    DOM_ACK    = '0;

    // Power-up, gap 2
    restart(0, 3);
    plan(0, 2);
    full = a_acc[ND-1] + 3;
    run(full);
    for (int k = 0; k < ND; k++) chk("s1_release_edge", 32'(rise[k]), 32'(5 + 4 * k));
    chk("s1_done_edge", 32'(done_at), 32'(18));

    // Gap 0: back-to-back releases two edges apart
    restart(0, 3);
    plan(0, 0);
    run(a_acc[ND-1] + 3);
    for (int k = 0; k < ND; k++) chk("s2_release_edge", 32'(rise[k]), 32'(5 + 2 * k));
    chk("s2_done_edge", 32'(done_at), 32'(12));

    // Ack stall on domain 1 for 10 extra cycles
    restart(0, 3);
    plan(0, 2);
    d_ack[1] = 10;
    sched();
    run(a_acc[ND-1] + 3);
    chk("s3_release2_edge", 32'(rise[2]), 32'(23));
    chk("s3_release3_edge", 32'(rise[3]), 32'(27));

    // SW request mid-gap after domains 0 and 1 are released
    restart(0, 1);
    plan(0, 2);
    run(10);
    chk("s4_pre_abort", 32'(DOM_RST_N), 32'(4'b0011));
    restart(1, 1);
    plan(0, 2);
    run(a_acc[ND-1] + 3);
    chk("s4_release0_edge", 32'(rise[0]), 32'(HC + 1));

    // SW request in DONE, then a 1-cycle RST during the new HOLD
    restart(1, 1);
    plan(0, 2);
    run(2);
    restart(0, 1);
    run(a_acc[ND-1] + 2);
    chk("s5_release0_edge", 32'(rise[0]), 32'(HC + 1));

    // SW request together with RST
    restart(2, 1);
    plan(0, 1);
    run(a_acc[ND-1] + 2);

    // Randomized delays, gaps, restarts and truncated sequences
    for (int r = 0; r < 30; r++) begin
      kind = int'($urandom_range(0, 2));
      restart(kind, int'($urandom_range(1, 3)));
      plan(1, 0);
      full = a_acc[ND-1] + 3;
      if ($urandom_range(0, 2) == 0) run(int'($urandom_range(1, full)));
      else run(full);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer for a multi-domain design.
- Holds every domain reset asserted, then releases them one at a time in index order. Each release waits for that domain's acknowledgement, then a programmable gap, before the next release.
- Each DOM_RST_N bit drives one per-domain reset synchronizer. Each DOM_ACK bit is the synchronized, released reset returned from that domain.
- Also supports a software-requested full re-sequence.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset domains (>=2).
- DLY_WIDTH, 8, width of DLY_GAP and the gap counter.
- HOLD_CYCLES, 4, cycles all resets stay asserted before the first release (>=1).
- ACK_TIMEOUT, 16, maximum cycles spent in WAIT_ACK before forced advance (used only with SEQ_ACK_TIMEOUT_EN).

Ports:
- CLK  input  1  single system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- SW_RST_REQ  input  1  single-cycle software request to restart the full sequence.
- DLY_GAP  input  DLY_WIDTH  gap cycles inserted after each ack; sampled on WAIT_ACK exit.
- DOM_ACK  input  NUM_DOMAINS  per-domain "reset released" acknowledge; level, active-high.
- DOM_RST_N  output  NUM_DOMAINS  per-domain reset request, active-low, registered.
- SEQ_BUSY  output  1  high while sequencing (HOLD/RELEASE/WAIT_ACK/GAP).
- SEQ_DONE  output  1  high when all domains are released.
- TIMEOUT_ERR  output  1  sticky; an ack timed out (see Optional Feature).

Behaviour:
- Reset (RST=1 at posedge):
  - state=HOLD, idx=0, counters=0
  - DOM_RST_N=all 0, SEQ_BUSY=1, SEQ_DONE=0, TIMEOUT_ERR=0
  - RST has priority over everything.
- All outputs are registered and take their new value at the same edge as the state transition that sets them.
- HOLD:
  - Counts HOLD_CYCLES cycles, then goes to RELEASE.
  - With RST deasserted before edge 1, DOM_RST_N[0] rises at edge HOLD_CYCLES+1.
- RELEASE (1 cycle): DOM_RST_N[idx]<=1; go to WAIT_ACK.
- WAIT_ACK:
  - Stays at least 1 cycle; DOM_ACK[idx] is checked at each edge.
  - On ack with idx==NUM_DOMAINS-1: go to DONE; SEQ_DONE<=1, SEQ_BUSY<=0.
  - On ack with otherwise DLY_GAP==0: go to RELEASE with idx+1.
  - On ack otherwise: go to GAP; load gap counter with DLY_GAP.
- GAP:
  - At counter==1: go to RELEASE with idx+1.
  - Otherwise decrement. GAP lasts exactly DLY_GAP cycles.
- Release spacing: with DOM_ACK wired directly to DOM_RST_N, consecutive releases are DLY_GAP+2 cycles apart. SEQ_DONE rises 1 cycle after the last release.
- DONE: outputs hold; SEQ_DONE=1 until RST or SW_RST_REQ.
- SW_RST_REQ (any state, including mid-sequence):
  - Next edge: state=HOLD, idx=0, DOM_RST_N=all 0, SEQ_DONE=0, SEQ_BUSY=1, TIMEOUT_ERR=0.
  - Sequence then reruns exactly as after RST.
  - SW_RST_REQ together with RST: RST wins (same result).
- Only the DOM_ACK[idx] bit is observed. Other ack bits are ignored, including acks from unreleased domains.
- An ack that drops after being accepted has no effect.
- Released DOM_RST_N bits never return low except via RST or SW_RST_REQ.
- A DLY_GAP change mid-GAP does not affect the running count.

Optional Feature:
- Macro SEQ_ACK_TIMEOUT_EN.
- Defined:
  - WAIT_ACK counts cycles.
  - On the ACK_TIMEOUT-th WAIT_ACK cycle with no ack, set TIMEOUT_ERR<=1 (sticky) and advance exactly as if acked.
  - Ack and timeout in the same cycle: treat as ack; no error.
- Not defined:
  - No timeout counter; WAIT_ACK waits indefinitely.
  - TIMEOUT_ERR is tied 0.

Test Plan:
- Power-up, defaults, DOM_ACK=DOM_RST_N, DLY_GAP=2, RST high 3 cycles then low:
  - DOM_RST_N[0] rises edge 5; bits 1..3 rise at edges 9, 13, 17.
  - SEQ_DONE=1 and SEQ_BUSY=0 at edge 18.
- DLY_GAP=0, same setup: releases at edges 5, 7, 9, 11; SEQ_DONE at edge 12.
- Ack stall: DOM_ACK[1] held low 10 extra cycles, DLY_GAP=2.
  - DOM_RST_N[2] rises 10 cycles later than in scenario 1.
  - DOM_RST_N[3:2] stay 0 during the stall.
- SW_RST_REQ pulse when DOM_RST_N=4'b0011 (mid-GAP):
  - Next edge DOM_RST_N=0000, SEQ_BUSY=1.
  - DOM_RST_N[0] rises HOLD_CYCLES+1 edges after the pulse.
- SW_RST_REQ in DONE, then RST asserted for 1 cycle during the new HOLD:
  - DOM_RST_N stays 0.
  - HOLD count restarts from RST deassertion.
- SEQ_ACK_TIMEOUT_EN defined, DOM_ACK[2] stuck 0:
  - TIMEOUT_ERR=1 after 16 WAIT_ACK cycles; DOM_RST_N[3] is still released.
  - SEQ_DONE=1; TIMEOUT_ERR is cleared by a following SW_RST_REQ.
